// File: rtl/tile_buf_pkg.sv
// rtl/tile_buf_pkg.sv - shared types and constants for the ping-pong tile buffer
package tile_buf_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tile_bank.sv
// rtl/tile_bank.sv - one tile register bank with a single write port and a combinational read port
module tile_bank
  import tile_buf_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int TILE_DEPTH = 16,
  parameter int ADDR_W     = $clog2(TILE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [TILE_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TILE_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tile_pingpong_buf.sv
// rtl/tile_pingpong_buf.sv - double-buffered A-tile store replaying each full tile REUSE times
// Optional stall counters: define TILE_BUF_STATS_EN.
module tile_pingpong_buf
  import tile_buf_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int TILE_DEPTH = 16,
  parameter int REUSE      = 4,
  parameter int ADDR_W     = $clog2(TILE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              load_valid_index,
  output logic              load_valid,
  output logic              read_valid,
  output logic              tile_loaded,
  output logic              tile_released
`ifdef TILE_BUF_STATS_EN
  ,
  output logic [STAT_W-1:0] in_stall_cnt,
  output logic [STAT_W-1:0] out_stall_cnt
`endif
);

  localparam int PASS_W = (REUSE > 1) ? $clog2(REUSE) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TILE_DEPTH - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(REUSE - 1);

  bank_state_e       state [2];
  logic              wr_sel;
  logic              rd_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [PASS_W-1:0] pass_cnt;
  logic [DATA_W-1:0] rdata [2];
  logic              in_fire;
  logic              out_fire;
  logic              fill_done;
  logic              release_bank;

  assign in_ready     = (state[wr_sel] != BANK_FULL);
  assign out_valid    = (state[rd_sel] == BANK_FULL);
  assign in_fire      = in_valid && in_ready;
  assign out_fire     = out_valid && out_ready;
  assign fill_done    = in_fire && (wr_addr == LAST_ADDR);
  assign release_bank = out_fire && (rd_addr == LAST_ADDR) && (pass_cnt == LAST_PASS);

  assign out_data         = rdata[rd_sel];
  assign out_last         = out_valid && (rd_addr == LAST_ADDR);
  assign load_valid_index = wr_sel;
  assign load_valid       = (state[wr_sel] == BANK_FILLING);
  assign read_valid       = out_valid;
  assign tile_loaded      = fill_done && !flush;
  assign tile_released    = release_bank && !flush;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_bank #(
      .DATA_W    (DATA_W),
      .TILE_DEPTH(TILE_DEPTH),
      .ADDR_W    (ADDR_W)
    ) u_bank (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (in_fire && !flush && (wr_sel == 1'(b))),
      .waddr(wr_addr),
      .wdata(in_data),
      .raddr(rd_addr),
      .rdata(rdata[b])
    );
  end

  // The writer and reader can never own the same bank while both fire a
  // state change, so the per-bank updates below never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state[0] <= BANK_EMPTY;
      state[1] <= BANK_EMPTY;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      pass_cnt <= '0;
    end else if (flush) begin
      state[0] <= BANK_EMPTY;
      state[1] <= BANK_EMPTY;
      wr_sel   <= 1'b0;
      rd_sel   <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      pass_cnt <= '0;
    end else begin
      if (in_fire) begin
        wr_addr <= fill_done ? '0 : wr_addr + 1'b1;
        if (fill_done) wr_sel <= ~wr_sel;
      end
      if (out_fire) begin
        if (rd_addr == LAST_ADDR) begin
          rd_addr  <= '0;
          pass_cnt <= (pass_cnt == LAST_PASS) ? '0 : pass_cnt + 1'b1;
        end else begin
          rd_addr <= rd_addr + 1'b1;
        end
        if (release_bank) rd_sel <= ~rd_sel;
      end
      for (int b = 0; b < 2; b++) begin
        if (in_fire && (wr_sel == b[0])) begin
          state[b] <= fill_done ? BANK_FULL : BANK_FILLING;
        end else if (release_bank && (rd_sel == b[0])) begin
          state[b] <= BANK_EMPTY;
        end
      end
    end
  end

`ifdef TILE_BUF_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_stall_cnt  <= '0;
      out_stall_cnt <= '0;
    end else if (flush) begin
      in_stall_cnt  <= '0;
      out_stall_cnt <= '0;
    end else begin
      if (in_valid && !in_ready)   in_stall_cnt  <= sat_inc(in_stall_cnt);
      if (out_valid && !out_ready) out_stall_cnt <= sat_inc(out_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_tile_pingpong_buf.sv
// tb/tb_tile_pingpong_buf.sv - self-checking bench: REUSE=2 and REUSE=1 instances against a tile-queue model
module tb_tile_pingpong_buf;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv [2];
  logic [31:0] id [2];
  logic        ordy [2];
  logic        fl [2];
  logic        irdy [2];
  logic        ov [2];
  logic [31:0] od [2];
  logic        ol [2];
  logic        lvi [2];
  logic        lv [2];
  logic        rv [2];
  logic        tl [2];
  logic        tr [2];
`ifdef TILE_BUF_STATS_EN
  logic [15:0] isc [2];
  logic [15:0] osc [2];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tile_pingpong_buf #(.DATA_W(32), .TILE_DEPTH(D), .REUSE(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_last(ol[0]),
    .load_valid_index(lvi[0]), .load_valid(lv[0]), .read_valid(rv[0]),
    .tile_loaded(tl[0]), .tile_released(tr[0])
`ifdef TILE_BUF_STATS_EN
    , .in_stall_cnt(isc[0]), .out_stall_cnt(osc[0])
`endif
  );

  tile_pingpong_buf #(.DATA_W(32), .TILE_DEPTH(D), .REUSE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_last(ol[1]),
    .load_valid_index(lvi[1]), .load_valid(lv[1]), .read_valid(rv[1]),
    .tile_loaded(tl[1]), .tile_released(tr[1])
`ifdef TILE_BUF_STATS_EN
    , .in_stall_cnt(isc[1]), .out_stall_cnt(osc[1])
`endif
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Model: a partially filled tile plus a queue of complete tiles (at most two).
  logic [31:0] pq [2][$];
  logic [31:0] fq [2][$];
  int ridx [2];
  int pass [2];
  int nfill [2];

  logic [31:0] bd [$];
  logic        bl [$];
  logic [31:0] b1 [$];
  int loaded0 = 0, released0 = 0, drops1 = 0;
  bit cont = 0;

  always @(negedge clk) begin
    int r, full_cnt;
    bit e_ir, e_ov, e_last, e_lv, in_fire, out_fire, e_tl, e_tr;
    if (ov[0] === 1'b1 && ordy[0]) begin bd.push_back(od[0]); bl.push_back(ol[0]); end
    if (ov[1] === 1'b1 && ordy[1]) b1.push_back(od[1]);
    if (tl[0] === 1'b1) loaded0++;
    if (tr[0] === 1'b1) released0++;
    if (cont && irdy[1] !== 1'b1) drops1++;
    for (int k = 0; k < 2; k++) begin
      r = (k == 0) ? 2 : 1;
      if (!rst_n) begin
        chk("rst_in_ready", k, irdy[k], 1);
        chk("rst_out_valid", k, ov[k], 0);
        chk("rst_out_last", k, ol[k], 0);
        chk("rst_out_data", k, od[k], 0);
        chk("rst_lvi", k, lvi[k], 0);
        chk("rst_lv", k, lv[k], 0);
        chk("rst_rv", k, rv[k], 0);
        pq[k].delete(); fq[k].delete();
        ridx[k] = 0; pass[k] = 0; nfill[k] = 0;
      end else begin
        full_cnt = fq[k].size() / D;
        e_ir     = full_cnt < 2;
        e_ov     = full_cnt > 0;
        e_last   = e_ov && ridx[k] == D - 1;
        e_lv     = pq[k].size() > 0;
        in_fire  = iv[k] && e_ir;
        out_fire = e_ov && ordy[k];
        e_tl     = !fl[k] && in_fire && pq[k].size() == D - 1;
        e_tr     = !fl[k] && out_fire && ridx[k] == D - 1 && pass[k] == r - 1;
        chk("in_ready", k, irdy[k], e_ir);
        chk("out_valid", k, ov[k], e_ov);
        chk("read_valid", k, rv[k], e_ov);
        chk("out_last", k, ol[k], e_last);
        chk("load_valid", k, lv[k], e_lv);
        chk("load_valid_index", k, lvi[k], nfill[k] % 2);
        chk("tile_loaded", k, tl[k], e_tl);
        chk("tile_released", k, tr[k], e_tr);
        if (e_ov) chk("out_data", k, od[k], fq[k][ridx[k]]);
        if (fl[k]) begin
          pq[k].delete(); fq[k].delete();
          ridx[k] = 0; pass[k] = 0; nfill[k] = 0;
        end else begin
          if (out_fire) begin
            ridx[k]++;
            if (ridx[k] == D) begin
              ridx[k] = 0;
              pass[k]++;
              if (pass[k] == r) begin
                pass[k] = 0;
                repeat (D) void'(fq[k].pop_front());
              end
            end
          end
          if (in_fire) begin
            pq[k].push_back(id[k]);
            if (pq[k].size() == D) begin
              foreach (pq[k][i]) fq[k].push_back(pq[k][i]);
              pq[k].delete();
              nfill[k]++;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [31:0] d);
    int n = 0;
    iv[0] = 1'b1;
    id[0] = d;
    while (irdy[0] !== 1'b1 && n < 50) begin step(); n++; end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL push0_timeout: in_ready stayed %b, required 1", irdy[0]);
    end
    step();
    iv[0] = 1'b0;
  endtask

  int bi = 0;
  task automatic exp_tile(input int base);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < D; i++) begin
        if (bi >= bd.size()) begin
          checks++; errors++;
          $display("FAIL beat_missing: got %0d beats, required more than %0d", bd.size(), bi);
        end else begin
          chk("beat_data", bi, bd[bi], base + i);
          chk("beat_last", bi, bl[bi], i == D - 1);
        end
        bi++;
      end
    end
  endtask

  task automatic clear_log();
    bd.delete(); bl.delete(); bi = 0; loaded0 = 0; released0 = 0;
  endtask

  initial begin
`ifdef TILE_BUF_STATS_EN
    logic [15:0] s0;
`endif
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; id[k] = 0; ordy[k] = 0; fl[k] = 0;
    end
    #3;
    chk("init_in_ready", 0, irdy[0], 1);
    chk("init_out_valid", 0, ov[0], 0);
    chk("init_out_data", 0, od[0], 0);
    chk("init_tile_loaded", 0, tl[0], 0);
    chk("init_tile_released", 0, tr[0], 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single tile, two passes
    clear_log();
    ordy[0] = 1'b1;
    for (int i = 0; i < D; i++) push0(i);
    repeat (12) step();
    exp_tile(0);
    chk("a_beats", 0, bd.size(), 8);
    chk("a_loaded", 0, loaded0, 1);
    chk("a_released", 0, released0, 1);

    // Both banks full under backpressure, then drain in order
    clear_log();
    ordy[0] = 1'b0;
    for (int i = 0; i < 2 * D; i++) push0(20 + i);
    step();
    chk("b_in_ready", 0, irdy[0], 0);
    chk("b_out_valid", 0, ov[0], 1);
    ordy[0] = 1'b1;
    repeat (20) step();
    exp_tile(20);
    exp_tile(24);
    chk("b_beats", 0, bd.size(), 16);
    chk("b_released", 0, released0, 2);

    // Mid-pass stall holds data
    clear_log();
    ordy[0] = 1'b0;
    for (int i = 0; i < D; i++) push0(30 + i);
    step();
    ordy[0] = 1'b1;
    step(); step();
    ordy[0] = 1'b0;
`ifdef TILE_BUF_STATS_EN
    s0 = osc[0];
`endif
    repeat (3) step();
    chk("c_hold_data", 0, od[0], 32);
    chk("c_hold_last", 0, ol[0], 0);
    chk("c_hold_valid", 0, ov[0], 1);
`ifdef TILE_BUF_STATS_EN
    chk("c_out_stall", 0, osc[0] - s0, 3);
`endif
    ordy[0] = 1'b1;
    repeat (12) step();
    exp_tile(30);
    chk("c_beats", 0, bd.size(), 8);

    // Flush a half-filled bank
    clear_log();
    push0(40); push0(41);
    fl[0] = 1'b1;
    step();
    fl[0] = 1'b0;
    chk("d_in_ready", 0, irdy[0], 1);
    chk("d_out_valid", 0, ov[0], 0);
    chk("d_lvi", 0, lvi[0], 0);
    chk("d_lv", 0, lv[0], 0);
    for (int i = 0; i < D; i++) push0(10 + i);
    repeat (12) step();
    exp_tile(10);
    chk("d_beats", 0, bd.size(), 8);

    // Asynchronous reset mid-read
    for (int i = 0; i < D; i++) push0(50 + i);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("e_out_valid", 0, ov[0], 0);
    chk("e_out_last", 0, ol[0], 0);
    chk("e_in_ready", 0, irdy[0], 1);
    chk("e_rv", 0, rv[0], 0);
    chk("e_out_data", 0, od[0], 0);
    chk("e_tile_released", 0, tr[0], 0);
    ordy[0] = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    // REUSE=1 continuous streaming
    b1.delete();
    cont = 1;
    iv[1] = 1'b1; ordy[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      id[1] = 100 + i;
      step();
    end
    cont = 0;
    iv[1] = 1'b0;
    repeat (8) step();
    chk("f_drops", 1, drops1, 0);
    chk("f_beats", 1, b1.size(), 40);
    for (int i = 0; i < 40 && i < b1.size(); i++) chk("f_order", i, b1[i], 100 + i);

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]   = $urandom_range(0, 3) != 0;
        id[k]   = $urandom;
        ordy[k] = $urandom_range(0, 3) != 0;
        fl[k]   = $urandom_range(0, 63) == 0;
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin iv[k] = 0; fl[k] = 0; end
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

endmodule
